// File: rtl/lfsr_checker_if.sv
// Code-stream and status bundle for lfsr_checker.
// err_sticky / lock_lost exist only when LFSR_CHK_STICKY_EN is defined.
interface lfsr_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             code_valid;
  logic [3:0]       code;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
`ifdef LFSR_CHK_STICKY_EN
  logic             err_sticky;
  logic             lock_lost;
`endif

  modport master (
    output code_valid, code,
`ifdef LFSR_CHK_STICKY_EN
    input  err_sticky, lock_lost,
`endif
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  code_valid, code,
`ifdef LFSR_CHK_STICKY_EN
    output err_sticky, lock_lost,
`endif
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side 4-bit LFSR checker: self-synchronises, locks, then counts mispredicted words.
// Optional sticky error / lock-lost flags enabled by defining LFSR_CHK_STICKY_EN.
module lfsr_checker #(
  parameter logic [3:0]  TAPS       = 4'b1100,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned CNT_W      = 8
) (
  input logic          clk,
  input logic          preset,
  lfsr_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_e;

  localparam logic [3:0] LOCK_L   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_L = 4'(UNLOCK_CNT);

  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], ^(q & TAPS)};
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       pred_q, pred_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             unlock_evt;
`ifdef LFSR_CHK_STICKY_EN
  logic             err_sticky_q, err_sticky_d;
  logic             lock_lost_q, lock_lost_d;
`endif

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    unlock_evt  = 1'b0;

    if (bus.code_valid) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (bus.code != '0) begin
            pred_d      = lfsr_next(bus.code);
            match_cnt_d = '0;
            state_d     = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (bus.code == pred_q) begin
            pred_d      = lfsr_next(pred_q);
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_d == LOCK_L) begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              miss_cnt_d = '0;
            end
          end else if (bus.code != '0) begin
            pred_d      = lfsr_next(bus.code);
            match_cnt_d = '0;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // Local model free-runs; received data never resyncs it while locked.
          pred_d = lfsr_next(pred_q);
          if (bus.code == pred_q) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_d == UNLOCK_L) begin
              state_d    = ST_SEARCH;
              locked_d   = 1'b0;
              unlock_evt = 1'b1;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

`ifdef LFSR_CHK_STICKY_EN
    err_sticky_d = err_sticky_q | err_pulse_d;
    lock_lost_d  = lock_lost_q | unlock_evt;
`endif
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      state_q      <= ST_SEARCH;
      pred_q       <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
`ifdef LFSR_CHK_STICKY_EN
      err_sticky_q <= 1'b0;
      lock_lost_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
`ifdef LFSR_CHK_STICKY_EN
      err_sticky_q <= err_sticky_d;
      lock_lost_q  <= lock_lost_d;
`endif
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
`ifdef LFSR_CHK_STICKY_EN
  assign bus.err_sticky = err_sticky_q;
  assign bus.lock_lost  = lock_lost_q;
`else
  logic unused_evt;
  assign unused_evt = unlock_evt;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default, and CNT_W=2/UNLOCK_CNT=15) against a chain-based model.
module tb_lfsr_checker;

  logic       clk;
  logic       in_v;
  logic [3:0] in_c;
  logic       in_rst;

  lfsr_checker_if #(.CNT_W(8)) ifa ();
  lfsr_checker_if #(.CNT_W(2)) ifb ();

  assign ifa.code_valid = in_v;
  assign ifa.code       = in_c;
  assign ifb.code_valid = in_v;
  assign ifb.code       = in_c;

  lfsr_checker #(.TAPS(4'b1100), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(8)) dut_a (
    .clk(clk), .preset(in_rst), .bus(ifa.slave)
  );
  lfsr_checker #(.TAPS(4'b1100), .LOCK_CNT(4), .UNLOCK_CNT(15), .CNT_W(2)) dut_b (
    .clk(clk), .preset(in_rst), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // x^4+x^3+1 successor via plain arithmetic
  function automatic int nx(input int q);
    return ((q << 1) & 15) | ($countones(q & 12) & 1);
  endfunction

  function automatic int unl_n(input int i);
    return (i == 0) ? 3 : 15;
  endfunction

  function automatic int cmax(input int i);
    return (i == 0) ? 255 : 3;
  endfunction

  localparam int LOCK_N = 4;

  // Model: while unlocked, track the length of the current valid chain of successors.
  bit mdl_ok = 1'b0;
  int m_locked[2], m_pulse[2], m_cnt[2], m_miss[2], m_exp[2];
  int ch_len[2], ch_last[2], m_sticky[2], m_lost[2];

  always @(posedge clk) begin
    if (in_rst) begin
      mdl_ok = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_locked[i] = 0; m_pulse[i] = 0; m_cnt[i] = 0; m_miss[i] = 0; m_exp[i] = 0;
        ch_len[i] = 0; ch_last[i] = 0; m_sticky[i] = 0; m_lost[i] = 0;
      end
    end else if (mdl_ok) begin
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] = 0;
        if (in_v) begin
          if (m_locked[i] != 0) begin
            if (int'(in_c) != m_exp[i]) begin
              m_pulse[i] = 1;
              m_sticky[i] = 1;
              if (m_cnt[i] < cmax(i)) m_cnt[i]++;
              m_miss[i]++;
            end else begin
              m_miss[i] = 0;
            end
            m_exp[i] = nx(m_exp[i]);
            if (m_miss[i] == unl_n(i)) begin
              m_locked[i] = 0;
              ch_len[i] = 0;
              m_lost[i] = 1;
            end
          end else begin
            if (ch_len[i] > 0 && int'(in_c) == nx(ch_last[i])) begin
              ch_len[i]++;
              ch_last[i] = int'(in_c);
            end else if (in_c != 4'd0) begin
              ch_len[i] = 1;
              ch_last[i] = int'(in_c);
            end else begin
              ch_len[i] = 0;
            end
            if (ch_len[i] == LOCK_N + 1) begin
              m_locked[i] = 1;
              m_exp[i] = nx(int'(in_c));
              m_miss[i] = 0;
              ch_len[i] = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("a_locked", ifa.locked, m_locked[0]);
      chk("a_err_pulse", ifa.err_pulse, m_pulse[0]);
      chk("a_err_count", ifa.err_count, m_cnt[0]);
      chk("b_locked", ifb.locked, m_locked[1]);
      chk("b_err_pulse", ifb.err_pulse, m_pulse[1]);
      chk("b_err_count", ifb.err_count, m_cnt[1]);
`ifdef LFSR_CHK_STICKY_EN
      chk("a_err_sticky", ifa.err_sticky, m_sticky[0]);
      chk("a_lock_lost", ifa.lock_lost, m_lost[0]);
      chk("b_err_sticky", ifb.err_sticky, m_sticky[1]);
      chk("b_lock_lost", ifb.lock_lost, m_lost[1]);
`endif
    end
  end

  task automatic step(input bit v, input logic [3:0] c, input bit r);
    in_v = v; in_c = c; in_rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c);
    step(1'b1, c, 1'b0);
  endtask

  initial begin
    int g;
    int r;
    in_v = 1'b0; in_c = 4'h0; in_rst = 1'b1;

    // reset
    step(1'b1, 4'h9, 1'b1);
    chk("rst_locked", ifa.locked, 0);
    chk("rst_count", ifa.err_count, 0);
    chk("rst_pulse", ifa.err_pulse, 0);

    // lock on 1,2,4,9,3
    send(4'h1); send(4'h2); send(4'h4); send(4'h9);
    chk("pre_lock", ifa.locked, 0);
    send(4'h3);
    chk("lock_a", ifa.locked, 1);
    chk("lock_b", ifb.locked, 1);
    chk("lock_cnt", ifa.err_count, 0);

    // single error: 0 replaces A
    send(4'h6); send(4'hD); send(4'h0);
    chk("single_pulse", ifa.err_pulse, 1);
    chk("single_cnt", ifa.err_count, 1);
    send(4'h5);
    chk("single_no_pulse", ifa.err_pulse, 0);
    send(4'hB);
    chk("single_locked", ifa.locked, 1);
    chk("single_cnt2", ifa.err_count, 1);

    // unlock: three wrong words where 7,F,E are expected
    send(4'h0); send(4'h0);
    chk("unlock_still", ifa.locked, 1);
    send(4'h0);
    chk("unlock_a", ifa.locked, 0);
    chk("unlock_cnt", ifa.err_count, 4);
    chk("unlock_b_sat", ifb.err_count, 3);
    chk("unlock_b_locked", ifb.locked, 1);
    send(4'h7); send(4'hF); send(4'hE); send(4'hC);
    chk("relock_pre", ifa.locked, 0);
    send(4'h8);
    chk("relock", ifa.locked, 1);
    chk("relock_cnt", ifa.err_count, 4);

    // search robustness
    step(1'b0, 4'h3, 1'b1);
    send(4'h0); send(4'h0); send(4'h1); send(4'h2); send(4'h4); send(4'h7);
    send(4'hF); send(4'hE); send(4'hC);
    chk("search_nolock", ifa.locked, 0);
    send(4'h8);
    chk("search_lock", ifa.locked, 1);

    // gaps: invalid cycles carry garbage
    g = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 0) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      else begin
        send(4'(g));
        g = nx(g);
      end
    end
    chk("gap_locked", ifa.locked, 1);
    chk("gap_cnt", ifa.err_count, 0);

    // preset mid-stream with garbage
    step(1'b1, 4'h5, 1'b1);
    chk("mid_rst_locked", ifa.locked, 0);
    chk("mid_rst_cnt", ifa.err_count, 0);
    chk("mid_rst_pulse", ifa.err_pulse, 0);

    // saturation on the 2-bit counter instance
    send(4'h1); send(4'h2); send(4'h4); send(4'h9); send(4'h3);
    for (int k = 0; k < 5; k++) begin
      send(4'h0);
      chk("sat_pulse_b", ifb.err_pulse, 1);
    end
    chk("sat_cnt_b", ifb.err_count, 3);
    chk("sat_locked_b", ifb.locked, 1);
    chk("sat_unlock_a", ifa.locked, 0);

    // randomized stream
    g = 1;
    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) step(1'b0, 4'($urandom_range(0, 15)), 1'b1);
      else if (r < 14) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      else if (r < 24) send(4'($urandom_range(0, 15)));
      else begin
        send(4'(g));
        g = nx(g);
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
